led_frame_sequencer: RTL and testbench
======================================

# led_frame_sequencer

- Frame sequencer directly upstream of the 8-lane LED shift-register serializer.
- Reads a bit-plane frame buffer, one byte per LED bit holding that bit for all 8 parallel strips, and presents each byte on `led_data` for one LED bit period.
- Brackets each frame with a latch/reset interval and emits a symbol-start strobe so the serializer can align its phase.

## Interface
Parameters:
- `NUM_LEDS`, 64: LEDs per strip; frame length is `NUM_LEDS*24` bit periods.
- `BIT_CYCLES`, 24: `sr_clk` cycles per LED bit period; legal range is 3 or more.
- `RESET_CYCLES`, 2000: `sr_clk` cycles of latch/reset after the last bit.
- `ADDR_W`, 11: frame-buffer address width; must satisfy 2^`ADDR_W` ≥ `NUM_LEDS*24`.

Ports:
- `sr_clk`  in  1  single clock, shared with the serializer.
- `ar`  in  1  reset, asynchronous, active-low.
- `frame_start`  in  1  one-cycle request to send one frame.
- `mem_rd`  out  1  frame-buffer read strobe.
- `mem_addr`  out  `ADDR_W`  read address, sequential in transmission order.
- `mem_data`  in  8  read data, valid the cycle after `mem_rd` is sampled (synchronous RAM, latency 1).
- `led_data`  out  8  current bit for strips 0..7; feeds the serializer data input.
- `led_reset`  out  1  high while lines must be held low (idle or latch).
- `sym_start`  out  1  one-cycle pulse on the first cycle of each bit period.
- `busy`  out  1  high from FETCH through LATCH.
- `frame_done`  out  1  one-cycle pulse when LATCH completes.

## Operation
- All outputs are registered.
- Reset values: `led_data`=0, `led_reset`=1, `busy`=0, `sym_start`=0, `frame_done`=0, `mem_rd`=0, `mem_addr`=0. State goes to IDLE, counters to 0.
- FSM states: IDLE, FETCH, SHOW, LATCH.
- IDLE:
  - Outputs: `led_reset`=1, `led_data`=0.
  - `frame_start`=1 moves to FETCH, with `mem_rd`=1 and `mem_addr`=0.
- FETCH:
  - Waits one cycle for `mem_data`.
  - Then `led_data`←`mem_data`, `sym_start`=1, `led_reset`=0, bit counter=0, and state goes to SHOW.
  - On that same transition, issue a prefetch: `mem_rd`=1, `mem_addr`=1.
- SHOW:
  - Bit-period counter runs 0..`BIT_CYCLES`-1.
  - Prefetched data is captured into a next-byte register one cycle after its read.
  - At the counter wrap, with more bits remaining: `led_data`←next byte, `sym_start`=1, and a prefetch for the following address is issued.
  - The last bit, at address `NUM_LEDS*24`-1, issues no prefetch.
  - After the last bit's period, state goes to LATCH.
- LATCH:
  - Outputs: `led_data`=0, `led_reset`=1.
  - Counts `RESET_CYCLES`, then pulses `frame_done` and returns to IDLE.
- `mem_rd` is high for exactly one cycle per address; there are exactly `NUM_LEDS*24` reads per frame.
- Address arithmetic is unsigned and never wraps within a frame. Counters are sized by `$clog2` of their terminal value.

## Timing
- Edge E0 samples `frame_start`: `mem_rd`=1 and `mem_addr`=0 after E0. `mem_data` is valid after E1. After E2, `led_data` holds byte 0 and `sym_start`=1.
- Latency from `frame_start` sampled to the first `led_data` is 2 cycles.
- `led_data` is stable for exactly `BIT_CYCLES` cycles per bit, and bit periods are back to back with no gaps.
- `busy` rises after E0 and falls on the cycle `frame_done` pulses.
- Frame duration, from `frame_start` sample to `frame_done` pulse: 2 + `NUM_LEDS*24*BIT_CYCLES` + `RESET_CYCLES` cycles.
- `frame_start` while `busy`=1 is ignored; it is not queued.
- `frame_start` coincident with the `frame_done` cycle is ignored; the FSM is still in LATCH.
- `ar` low mid-frame immediately forces the reset values. No `frame_done` is emitted.
- After reset release, the block waits in IDLE for a new `frame_start`.

## Configuration
- `LED_SEQ_AUTO_REPEAT_EN` defined: LATCH completion pulses `frame_done` and goes directly to FETCH at address 0, with `busy` staying 1. This gives continuous refresh after a single `frame_start`, and only `ar` stops it.
- `LED_SEQ_AUTO_REPEAT_EN` undefined: LATCH returns to IDLE as described in Operation.

## Test plan
- Reset value check:
  - Stimulus: assert `ar`=0 asynchronously mid-cycle.
  - Required: `led_data`=0, `led_reset`=1, `busy`=0 without waiting for a clock edge.
- Single frame (`NUM_LEDS`=2, `BIT_CYCLES`=24, `RESET_CYCLES`=10, RAM preloaded with address value):
  - Stimulus: one `frame_start` pulse.
  - Required: `led_data` steps 0x00..0x2F, each held 24 cycles, with 48 `sym_start` pulses.
  - Then `led_reset`=1 for 10 cycles and `frame_done` at cycle 2+1152+10 = 1164.
- Busy collision:
  - Stimulus: pulse `frame_start` at cycles 100 and 1163 of a frame.
  - Required: both are ignored; exactly 48 reads and one `frame_done`.
- Mid-frame reset:
  - Stimulus: `ar`=0 during bit 20.
  - Required: outputs return to reset values and there is no `frame_done`.
  - Then a fresh `frame_start` restarts from `mem_addr`=0.
- Minimum `BIT_CYCLES`=3:
  - Required: the prefetch still lands in time; no stale byte appears, checked against the RAM contents.
- `LED_SEQ_AUTO_REPEAT_EN` defined:
  - Stimulus: one `frame_start`.
  - Required: after `frame_done`, the next `mem_rd` to address 0 follows on the next cycle. Three consecutive frames are identical.

Source files
------------

// File: rtl/led_frame_sequencer.sv
// Bit-plane frame sequencer feeding the 8-lane LED serializer (optional LED_SEQ_AUTO_REPEAT_EN: continuous refresh).
// Latency: frame_start sampled to first led_data byte is 2 cycles; each byte is held BIT_CYCLES, then RESET_CYCLES of latch.
// Backpressure: none; frame_start is honoured only in IDLE and is dropped (not queued) at any other time.
module led_frame_sequencer #(
    parameter int NUM_LEDS     = 64,
    parameter int BIT_CYCLES   = 24,
    parameter int RESET_CYCLES = 2000,
    parameter int ADDR_W       = 11
) (
    input  logic              sr_clk,
    input  logic              ar,
    input  logic              frame_start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        led_data,
    output logic              led_reset,
    output logic              sym_start,
    output logic              busy,
    output logic              frame_done
);

    localparam int TOTAL_BITS = NUM_LEDS * 24;
    localparam int BC_W       = $clog2(BIT_CYCLES);
    localparam int LAT_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [BC_W-1:0]   BIT_LAST   = BC_W'(BIT_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(TOTAL_BITS - 1);
    localparam logic [ADDR_W-1:0] IDX_PENULT = ADDR_W'(TOTAL_BITS - 2);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHOW,
        LATCH
    } state_t;

    state_t            state_q, state_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        led_data_q, led_data_d;
    logic              led_reset_q, led_reset_d;
    logic              sym_start_q, sym_start_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] bit_idx_q, bit_idx_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [7:0]        next_byte_q, next_byte_d;
    logic              rd_dly_q, rd_dly_d;

    always_comb begin
        state_d      = state_q;
        mem_rd_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        led_data_d   = led_data_q;
        led_reset_d  = led_reset_q;
        sym_start_d  = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        lat_cnt_d    = lat_cnt_q;
        // rd_dly_q marks the cycle the RAM output holds the byte just read
        rd_dly_d     = mem_rd_q;
        next_byte_d  = rd_dly_q ? mem_data : next_byte_q;

        case (state_q)
            IDLE: begin
                led_reset_d = 1'b1;
                led_data_d  = 8'h00;
                busy_d      = 1'b0;
                if (frame_start) begin
                    state_d    = FETCH;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = '0;
                    busy_d     = 1'b1;
                end
            end

            FETCH: begin
                // First FETCH cycle is the RAM latency; byte 0 is on mem_data in the second.
                if (!mem_rd_q) begin
                    state_d     = SHOW;
                    led_data_d  = mem_data;
                    sym_start_d = 1'b1;
                    led_reset_d = 1'b0;
                    bit_cnt_d   = '0;
                    bit_idx_d   = '0;
                    mem_rd_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(1);
                end
            end

            SHOW: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d     = LATCH;
                        led_data_d  = 8'h00;
                        led_reset_d = 1'b1;
                        lat_cnt_d   = '0;
                    end else begin
                        led_data_d  = next_byte_q;
                        sym_start_d = 1'b1;
                        bit_idx_d   = bit_idx_q + ADDR_W'(1);
                        // The final byte was already prefetched when entering the penultimate bit.
                        if (bit_idx_q != IDX_PENULT) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                        end
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
            end

            LATCH: begin
                led_data_d  = 8'h00;
                led_reset_d = 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    frame_done_d = 1'b1;
`ifdef LED_SEQ_AUTO_REPEAT_EN
                    state_d    = FETCH;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = '0;
`else
                    state_d    = IDLE;
                    busy_d     = 1'b0;
`endif
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sr_clk or negedge ar) begin
        if (!ar) begin
            state_q      <= IDLE;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            led_data_q   <= 8'h00;
            led_reset_q  <= 1'b1;
            sym_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            lat_cnt_q    <= '0;
            next_byte_q  <= 8'h00;
            rd_dly_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            led_data_q   <= led_data_d;
            led_reset_q  <= led_reset_d;
            sym_start_q  <= sym_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            lat_cnt_q    <= lat_cnt_d;
            next_byte_q  <= next_byte_d;
            rd_dly_q     <= rd_dly_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign led_data   = led_data_q;
    assign led_reset  = led_reset_q;
    assign sym_start  = sym_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: two instances (24 and 3 cycles per bit) checked every cycle against a timeline model.
module tb_led_frame_sequencer;

    localparam int NL  = 2;
    localparam int TOT = NL * 24;
    localparam int R   = 10;
    localparam int BCA = 24;
    localparam int BCB = 3;
    localparam int AW  = 11;
    localparam int PA  = 2 + TOT * BCA + R;   // 1164
    localparam int PB  = 2 + TOT * BCB + R;   // 156
`ifdef LED_SEQ_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [7:0]    led;
        logic          lr;
        logic          sym;
        logic          busy;
        logic          done;
    } obs_t;

    logic          sr_clk = 1'b0;
    logic          ar = 1'b1;
    logic          frame_start = 1'b0;
    logic          mem_rd_a, mem_rd_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [7:0]    mem_data_a = 8'h00, mem_data_b = 8'h00;
    logic [7:0]    led_data_a, led_data_b;
    logic          led_reset_a, led_reset_b, sym_start_a, sym_start_b;
    logic          busy_a, busy_b, frame_done_a, frame_done_b;

    logic [7:0] ram_a [TOT];
    logic [7:0] ram_b [TOT];

    int total = 0, bad = 0;
    int cyc = 0, e0 = 0;
    bit act_a = 0, act_b = 0;
    int k_a = 0, k_b = 0;
    int rd_cnt_a = 0, sym_cnt_a = 0, done_cnt_a = 0, done_k_a = -1;
    int rd_cnt_b = 0, done_cnt_b = 0, done_k_b = -1;

    led_frame_sequencer #(.NUM_LEDS(NL), .BIT_CYCLES(BCA), .RESET_CYCLES(R), .ADDR_W(AW)) dut_a (
        .sr_clk(sr_clk), .ar(ar), .frame_start(frame_start),
        .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .led_data(led_data_a), .led_reset(led_reset_a), .sym_start(sym_start_a),
        .busy(busy_a), .frame_done(frame_done_a));

    led_frame_sequencer #(.NUM_LEDS(NL), .BIT_CYCLES(BCB), .RESET_CYCLES(R), .ADDR_W(AW)) dut_b (
        .sr_clk(sr_clk), .ar(ar), .frame_start(frame_start),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .led_data(led_data_b), .led_reset(led_reset_b), .sym_start(sym_start_b),
        .busy(busy_b), .frame_done(frame_done_b));

    always #5 sr_clk = ~sr_clk;

    // Synchronous RAMs, one cycle read latency; out-of-range reads return a poison byte.
    always @(posedge sr_clk) begin
        if (mem_rd_a) mem_data_a <= (mem_addr_a < AW'(TOT)) ? ram_a[mem_addr_a[5:0]] : 8'hEE;
        if (mem_rd_b) mem_data_b <= (mem_addr_b < AW'(TOT)) ? ram_b[mem_addr_b[5:0]] : 8'hEE;
    end

    // Expected outputs k edges after the edge that accepted frame_start.
    function automatic obs_t model(bit act, int k, int bc, bit use_b);
        int   n, p, kk, j;
        obs_t e;
        n = TOT * bc;
        p = 2 + n + R;
        e = '0;
        e.lr = 1'b1;
        if (!act) return e;
        if (AUTO) begin
            kk = k % p;
            e.done = (k > 0 && kk == 0);
        end else begin
            if (k >= p) begin
                e.done = (k == p);
                return e;
            end
            kk = k;
        end
        e.busy = 1'b1;
        if (kk == 0) begin
            e.rd   = 1'b1;
            e.addr = '0;
        end
        if (kk >= 2) begin
            j = (kk - 2) / bc;
            if ((kk - 2) % bc == 0 && j <= TOT - 2) begin
                e.rd   = 1'b1;
                e.addr = AW'(j + 1);
            end
            if (j < TOT) begin
                e.led = use_b ? ram_b[j] : ram_a[j];
                e.lr  = 1'b0;
                e.sym = ((kk - 2) % bc == 0);
            end
        end
        return e;
    endfunction

    always @(posedge sr_clk or negedge ar) begin
        if (!ar) begin
            act_a = 0; k_a = 0; act_b = 0; k_b = 0;
        end else begin
            cyc = cyc + 1;
            if ((!act_a || (!AUTO && k_a >= PA)) && frame_start) begin
                act_a = 1; k_a = 0;
            end else if (act_a) begin
                k_a = k_a + 1;
                if (!AUTO && k_a > PA) act_a = 0;
            end
            if ((!act_b || (!AUTO && k_b >= PB)) && frame_start) begin
                act_b = 1; k_b = 0;
            end else if (act_b) begin
                k_b = k_b + 1;
                if (!AUTO && k_b > PB) act_b = 0;
            end
        end
    end

    task automatic chk(string nm, obs_t got, obs_t e);
        total++;
        if (got.rd !== e.rd || (e.rd && got.addr !== e.addr) || got.led !== e.led ||
            got.lr !== e.lr || got.sym !== e.sym || got.busy !== e.busy || got.done !== e.done) begin
            bad++;
            $display("FAIL %s cyc=%0d got rd=%b addr=%0d led=%h rst=%b sym=%b busy=%b done=%b want rd=%b addr=%0d led=%h rst=%b sym=%b busy=%b done=%b",
                     nm, cyc, got.rd, got.addr, got.led, got.lr, got.sym, got.busy, got.done,
                     e.rd, e.addr, e.led, e.lr, e.sym, e.busy, e.done);
        end
    endtask

    task automatic lit(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    always @(negedge sr_clk) begin
        if (ar) begin
            chk("cycle_a", {mem_rd_a, mem_addr_a, led_data_a, led_reset_a, sym_start_a, busy_a, frame_done_a},
                model(act_a, k_a, BCA, 1'b0));
            chk("cycle_b", {mem_rd_b, mem_addr_b, led_data_b, led_reset_b, sym_start_b, busy_b, frame_done_b},
                model(act_b, k_b, BCB, 1'b1));
            if (mem_rd_a) rd_cnt_a++;
            if (sym_start_a) sym_cnt_a++;
            if (frame_done_a) begin
                done_cnt_a++;
                if (done_k_a < 0) done_k_a = cyc - e0;
            end
            if (mem_rd_b) rd_cnt_b++;
            if (frame_done_b) begin
                done_cnt_b++;
                if (done_k_b < 0) done_k_b = cyc - e0;
            end
        end
    end

    task automatic clear_counts();
        rd_cnt_a = 0; sym_cnt_a = 0; done_cnt_a = 0; done_k_a = -1;
        rd_cnt_b = 0; done_cnt_b = 0; done_k_b = -1;
    endtask

    task automatic pulse_start();
        @(posedge sr_clk);
        #2 frame_start = 1'b1;
        @(posedge sr_clk);
        #2;
        e0 = cyc;
        frame_start = 1'b0;
    endtask

    task automatic goto(int k);
        while (cyc < e0 + k) begin
            @(posedge sr_clk);
            #1;
        end
        #2;
    endtask

    task automatic check_reset_vals(string tag);
        lit({tag, "_led_data"}, int'(led_data_a), 0);
        lit({tag, "_led_reset"}, int'(led_reset_a), 1);
        lit({tag, "_busy"}, int'(busy_a), 0);
        lit({tag, "_mem_rd"}, int'(mem_rd_a), 0);
        lit({tag, "_mem_addr"}, int'(mem_addr_a), 0);
        lit({tag, "_sym_done"}, int'({sym_start_a, frame_done_a, busy_b}), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < TOT; i++) begin
            ram_a[i] = 8'(i);
            ram_b[i] = 8'((i * 37 + 11) & 255);
        end
        #1 ar = 1'b0;
        #2 check_reset_vals("por");
        @(posedge sr_clk);
        @(posedge sr_clk);
        #2 ar = 1'b1;
        repeat (3) @(posedge sr_clk);

`ifdef LED_SEQ_AUTO_REPEAT_EN
        clear_counts();
        pulse_start();
        goto(PA);
        lit("auto_done", int'(frame_done_a), 1);
        lit("auto_rd0", int'(mem_rd_a), 1);
        lit("auto_addr0", int'(mem_addr_a), 0);
        lit("auto_busy", int'(busy_a), 1);
        goto(3 * PA + 5);
        lit("auto_done_cnt", done_cnt_a, 3);
        lit("auto_rd_cnt", rd_cnt_a, 3 * TOT + 2);
        ar = 1'b0;
        #1 check_reset_vals("auto_stop");
        @(posedge sr_clk);
        #2 ar = 1'b1;
        repeat (5) @(posedge sr_clk);
`else
        // Single frame, with frame_start collisions at k=100 and at the frame_done edge.
        clear_counts();
        pulse_start();
        lit("k0_mem_rd", int'(mem_rd_a), 1);
        lit("k0_mem_addr", int'(mem_addr_a), 0);
        lit("k0_busy", int'(busy_a), 1);
        goto(1);
        lit("k1_mem_rd", int'(mem_rd_a), 0);
        goto(2);
        lit("k2_led", int'(led_data_a), 8'h00);
        lit("k2_sym", int'(sym_start_a), 1);
        lit("k2_led_reset", int'(led_reset_a), 0);
        lit("k2_led_b", int'(led_data_b), 8'h0B);
        goto(99);
        frame_start = 1'b1;
        goto(100);
        frame_start = 1'b0;
        goto(122);
        lit("bit5_led", int'(led_data_a), 8'h05);
        lit("bit5_sym", int'(sym_start_a), 1);
        goto(1153);
        lit("bit47_led", int'(led_data_a), 8'h2F);
        goto(1154);
        lit("latch_led_reset", int'(led_reset_a), 1);
        goto(1163);
        frame_start = 1'b1;
        goto(1164);
        frame_start = 1'b0;
        lit("k1164_done", int'(frame_done_a), 1);
        lit("k1164_busy", int'(busy_a), 0);
        goto(1330);
        lit("frame_reads", rd_cnt_a, 48);
        lit("frame_syms", sym_cnt_a, 48);
        lit("frame_dones", done_cnt_a, 1);
        lit("frame_done_cycle", done_k_a, 1164);
        lit("b_done_cycle", done_k_b, PB);
        lit("b_reads", rd_cnt_b, 96);

        // Mid-frame asynchronous reset during bit 20, then a clean restart.
        clear_counts();
        pulse_start();
        goto(490);
        ar = 1'b0;
        #1 check_reset_vals("midrst");
        @(posedge sr_clk);
        #2 ar = 1'b1;
        repeat (5) @(posedge sr_clk);
        #2;
        lit("midrst_no_done", done_cnt_a, 0);
        lit("midrst_idle_busy", int'(busy_a), 0);
        clear_counts();
        pulse_start();
        lit("restart_mem_rd", int'(mem_rd_a), 1);
        lit("restart_mem_addr", int'(mem_addr_a), 0);
        goto(PA + 2);
        lit("restart_dones", done_cnt_a, 1);
        lit("restart_reads", rd_cnt_a, 48);
        lit("restart_done_cycle", done_k_a, PA);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
